// File: rtl/snapshot_mem_pkg.sv
// Shared definitions for the snapshot memory access bridge: one-hot FSM
// encodings and elaboration-time sizing helpers.
// Optional feature macro used by the top: SNAP_MEM_TIMEOUT_EN.
package snapshot_mem_pkg;

    // One-hot state indices, used for single-bit state decodes.
    localparam int S_IDLE_IDX = 0;
    localparam int S_WAIT_IDX = 1;
    localparam int S_RESP_IDX = 2;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'b001,
        ST_MEM_WAIT = 3'b010,
        ST_RESP     = 3'b100
    } state_t;

    // Ceiling log2; returns 0 for v <= 1.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    // Number of bus-width partitions needed to hold one memory entry.
    function automatic int part_cnt(input int mem_w, input int data_w);
        return (mem_w + data_w - 1) / data_w;
    endfunction

    // Width of partition idx; only the last one can be narrower than data_w.
    function automatic int part_width(input int mem_w, input int data_w, input int idx);
        if ((idx == part_cnt(mem_w, data_w) - 1) && ((mem_w % data_w) != 0))
            return mem_w % data_w;
        return data_w;
    endfunction

endpackage

// File: rtl/snapshot_part_buf.sv
// Snapshot buffer holding one memory entry as PART_CNT bus-width partitions.
// Supports a full-entry load, a single-partition write, a partition read mux
// and a merged view with one partition replaced (used as commit data).
// Storage is padded to PART_CNT*DATA_WIDTH; the padding bits are never written
// and stay zero, which gives zero-padded reads of the short last partition.
module snapshot_part_buf
    import snapshot_mem_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int MEM_WIDTH  = 72,
    parameter int PART_CNT   = 3,
    parameter int PART_W     = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load_en,
    input  logic [MEM_WIDTH-1:0]  load_data,
    input  logic                  wr_en,
    input  logic [PART_W-1:0]     wr_part,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [PART_W-1:0]     rd_part,
    output logic [DATA_WIDTH-1:0] rd_data,
    input  logic [PART_W-1:0]     merge_part,
    input  logic [DATA_WIDTH-1:0] merge_data,
    output logic [MEM_WIDTH-1:0]  merged
);

    localparam int PAD_W = PART_CNT * DATA_WIDTH;

    logic [PAD_W-1:0] buf_q;
    logic [PAD_W-1:0] buf_d;

    // Next buffer contents: full load has priority over a partition write;
    // bits beyond the partition width are dropped.
    always_comb begin
        buf_d = buf_q;
        if (load_en) begin
            buf_d = PAD_W'(load_data);
        end else if (wr_en) begin
            for (int i = 0; i < PART_CNT; i++) begin
                if (wr_part == PART_W'(i)) begin
                    for (int b = 0; b < part_width(MEM_WIDTH, DATA_WIDTH, i); b++)
                        buf_d[i*DATA_WIDTH + b] = wr_data[b];
                end
            end
        end
    end

    // Buffer register, cleared on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) buf_q <= '0;
        else        buf_q <= buf_d;
    end

    // Partition read mux; an out-of-range partition reads as zero.
    always_comb begin
        rd_data = '0;
        for (int i = 0; i < PART_CNT; i++) begin
            if (rd_part == PART_W'(i))
                rd_data = buf_q[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Entry-width view of the buffer with merge_part replaced by merge_data.
    always_comb begin
        merged = buf_q[MEM_WIDTH-1:0];
        for (int i = 0; i < PART_CNT; i++) begin
            if (merge_part == PART_W'(i)) begin
                for (int b = 0; b < part_width(MEM_WIDTH, DATA_WIDTH, i); b++)
                    merged[i*DATA_WIDTH + b] = merge_data[b];
            end
        end
    end

endmodule

// File: rtl/snapshot_mem_access.sv
// Register-bus to wide-memory bridge. Reading partition 0 of an entry fetches
// the whole entry into a snapshot; writing the commit partition writes the
// snapshot plus the write word back as one memory write. Other partitions are
// served locally from the snapshot.
// Handshake: the requester raises req_vld and holds it until the one-cycle
// ack_vld pulse; req_vld is only sampled in IDLE. Towards memory, mem_req_vld
// is a level held with stable address/data until mem_ack_vld is seen.
// Optional feature: define SNAP_MEM_TIMEOUT_EN to bound MEM_WAIT to
// TIMEOUT_CYC cycles and report err on expiry.
module snapshot_mem_access
    import snapshot_mem_pkg::*;
#(
    parameter int                  DATA_WIDTH     = 32,
    parameter int                  MEM_WIDTH      = 72,
    parameter int                  ADDR_WIDTH     = 10,
    parameter int                  ENTRY_WIDTH    = 6,
    parameter bit                  SUB            = 1'b0,
    parameter int                  BASE           = 0,
    parameter logic [MEM_WIDTH-1:0] RST_VALUE     = '0,
    parameter bit                  WR_COMMIT_LAST = 1'b1,
    parameter int                  TIMEOUT_CYC    = 255
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   req_vld,
    input  logic [ADDR_WIDTH-1:0]  addr,
    input  logic                   rd_en,
    input  logic                   wr_en,
    input  logic [DATA_WIDTH-1:0]  wr_data,
    output logic                   ack_vld,
    output logic [DATA_WIDTH-1:0]  rd_data,
    output logic                   err,
    input  logic                   entry_vld,
    input  logic                   entry_write_protect_en,
    output logic                   mem_req_vld,
    input  logic                   mem_ack_vld,
    output logic [ENTRY_WIDTH-1:0] mem_addr,
    output logic                   mem_rd_en,
    output logic                   mem_wr_en,
    output logic [MEM_WIDTH-1:0]   mem_wr_data,
    input  logic [MEM_WIDTH-1:0]   mem_rd_data
);

    localparam int PART_CNT = part_cnt(MEM_WIDTH, DATA_WIDTH);
    localparam int LSB      = clog2(DATA_WIDTH / 8);
    localparam int PBITS    = clog2(PART_CNT);
    localparam int PART_W   = (PBITS == 0) ? 1 : PBITS;
    localparam logic [PART_W-1:0] COMMIT = WR_COMMIT_LAST ? PART_W'(PART_CNT - 1) : '0;

    state_t state, state_nxt;

    logic [ADDR_WIDTH-1:0]  valid_addr;
    logic [PART_W-1:0]      req_part;
    logic [ENTRY_WIDTH-1:0] req_entry;
    logic                   unused_addr;
    logic req_rd, req_wr, part_ok, rd_mem, rd_rst, wr_mem, wr_local;

    logic [PART_W-1:0]      part_ff;
    logic [ENTRY_WIDTH-1:0] entry_ff;
    logic [DATA_WIDTH-1:0]  wr_data_ff;
    logic rd_ff, mem_rd_ff, mem_wr_ff;

    logic accept, buf_load, load_sel_mem, buf_wr, wr_sel_ff;
    logic [MEM_WIDTH-1:0]  buf_load_data;
    logic [PART_W-1:0]     buf_wr_part;
    logic [DATA_WIDTH-1:0] buf_wr_data;
    logic [DATA_WIDTH-1:0] buf_rd_data;
    logic [MEM_WIDTH-1:0]  merged;
    logic in_wait;

`ifdef SNAP_MEM_TIMEOUT_EN
    logic [15:0] tmo_cnt;
    logic        err_ff;
    logic        timeout_hit;
`endif

    // Address decode: byte offset, then partition, then entry index.
    assign valid_addr = SUB ? (addr - ADDR_WIDTH'(BASE)) : addr;
    assign unused_addr = ^valid_addr;
    generate
        if (PBITS > 0) begin : g_part_dec
            assign req_part = valid_addr[LSB +: PBITS];
        end else begin : g_part_zero
            assign req_part = '0;
        end
    endgenerate
    assign req_entry = valid_addr[LSB + PBITS +: ENTRY_WIDTH];

    // Request classification; a write wins when both enables are high.
    assign req_wr   = wr_en;
    assign req_rd   = rd_en & ~wr_en;
    assign part_ok  = {1'b0, req_part} < (PART_W + 1)'(PART_CNT);
    assign rd_mem   = req_rd & (req_part == '0) & entry_vld;
    assign rd_rst   = req_rd & (req_part == '0) & ~entry_vld;
    assign wr_mem   = req_wr & (req_part == COMMIT) & ~entry_write_protect_en;
    assign wr_local = req_wr & part_ok & ~wr_mem;

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic and snapshot update strobes.
    always_comb begin
        state_nxt    = state;
        accept       = 1'b0;
        buf_load     = 1'b0;
        load_sel_mem = 1'b0;
        buf_wr       = 1'b0;
        wr_sel_ff    = 1'b0;
`ifdef SNAP_MEM_TIMEOUT_EN
        timeout_hit  = 1'b0;
`endif
        case (state)
            ST_IDLE: begin
                if (req_vld) begin
                    accept    = 1'b1;
                    state_nxt = (rd_mem | wr_mem) ? ST_MEM_WAIT : ST_RESP;
                    buf_load  = rd_rst;
                    buf_wr    = wr_local;
                end
            end
            ST_MEM_WAIT: begin
                if (mem_ack_vld) begin
                    state_nxt    = ST_RESP;
                    buf_load     = mem_rd_ff;
                    load_sel_mem = mem_rd_ff;
                    buf_wr       = mem_wr_ff;
                    wr_sel_ff    = mem_wr_ff;
                end
`ifdef SNAP_MEM_TIMEOUT_EN
                else if (tmo_cnt == 16'(TIMEOUT_CYC - 1)) begin
                    state_nxt   = ST_RESP;
                    timeout_hit = 1'b1;
                end
`endif
            end
            ST_RESP:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Request capture on accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            part_ff    <= '0;
            entry_ff   <= '0;
            wr_data_ff <= '0;
            rd_ff      <= 1'b0;
            mem_rd_ff  <= 1'b0;
            mem_wr_ff  <= 1'b0;
        end else if (accept) begin
            part_ff    <= req_part;
            entry_ff   <= req_entry;
            wr_data_ff <= wr_data;
            rd_ff      <= req_rd;
            mem_rd_ff  <= rd_mem;
            mem_wr_ff  <= wr_mem;
        end
    end

`ifdef SNAP_MEM_TIMEOUT_EN
    // MEM_WAIT cycle counter and sticky-per-request timeout flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt <= '0;
            err_ff  <= 1'b0;
        end else if (accept) begin
            tmo_cnt <= '0;
            err_ff  <= 1'b0;
        end else begin
            if (state == ST_MEM_WAIT) tmo_cnt <= tmo_cnt + 16'd1;
            if (timeout_hit)          err_ff  <= 1'b1;
        end
    end
`endif

    // Snapshot write sources: live request at accept, captured word on commit ack.
    assign buf_load_data = load_sel_mem ? mem_rd_data : RST_VALUE;
    assign buf_wr_part   = wr_sel_ff ? COMMIT : req_part;
    assign buf_wr_data   = wr_sel_ff ? wr_data_ff : wr_data;

    snapshot_part_buf #(
        .DATA_WIDTH (DATA_WIDTH),
        .MEM_WIDTH  (MEM_WIDTH),
        .PART_CNT   (PART_CNT),
        .PART_W     (PART_W)
    ) u_buf (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_en    (buf_load),
        .load_data  (buf_load_data),
        .wr_en      (buf_wr),
        .wr_part    (buf_wr_part),
        .wr_data    (buf_wr_data),
        .rd_part    (part_ff),
        .rd_data    (buf_rd_data),
        .merge_part (COMMIT),
        .merge_data (wr_data_ff),
        .merged     (merged)
    );

    // Output decode; everything is zero outside the states that own it.
    assign ack_vld     = state[S_RESP_IDX];
    assign in_wait     = state[S_WAIT_IDX];
    assign mem_req_vld = in_wait;
    assign mem_addr    = in_wait ? entry_ff : '0;
    assign mem_rd_en   = in_wait & mem_rd_ff;
    assign mem_wr_en   = in_wait & mem_wr_ff;
    assign mem_wr_data = (in_wait & mem_wr_ff) ? merged : '0;
`ifdef SNAP_MEM_TIMEOUT_EN
    assign rd_data = (ack_vld & rd_ff & ~err_ff) ? buf_rd_data : '0;
    assign err     = ack_vld & err_ff;
`else
    assign rd_data = (ack_vld & rd_ff) ? buf_rd_data : '0;
    assign err     = 1'b0;
`endif

endmodule

// File: tb/tb_snapshot_mem_access.sv
// Directed bench for snapshot_mem_access with DATA_WIDTH=32, MEM_WIDTH=72
// (three partitions, commit on partition 2). Address map: part = addr[3:2],
// entry = addr[9:4]. Latency is counted in cycles including the cycle the
// request is presented: local ops ack at 2, memory ops at 2 + MEM_WAIT cycles.
module tb_snapshot_mem_access;

    logic        clk;
    logic        rst_n;
    logic        req_vld;
    logic [9:0]  addr;
    logic        rd_en;
    logic        wr_en;
    logic [31:0] wr_data;
    logic        ack_vld;
    logic [31:0] rd_data;
    logic        err;
    logic        entry_vld;
    logic        entry_write_protect_en;
    logic        mem_req_vld;
    logic        mem_ack_vld;
    logic [5:0]  mem_addr;
    logic        mem_rd_en;
    logic        mem_wr_en;
    logic [71:0] mem_wr_data;
    logic [71:0] mem_rd_data;

    int checks;
    int failures;

    snapshot_mem_access #(
        .DATA_WIDTH     (32),
        .MEM_WIDTH      (72),
        .ADDR_WIDTH     (10),
        .ENTRY_WIDTH    (6),
        .SUB            (1'b0),
        .BASE           (0),
        .RST_VALUE      (72'h5A),
        .WR_COMMIT_LAST (1'b1),
        .TIMEOUT_CYC    (8)
    ) dut (
        .clk                    (clk),
        .rst_n                  (rst_n),
        .req_vld                (req_vld),
        .addr                   (addr),
        .rd_en                  (rd_en),
        .wr_en                  (wr_en),
        .wr_data                (wr_data),
        .ack_vld                (ack_vld),
        .rd_data                (rd_data),
        .err                    (err),
        .entry_vld              (entry_vld),
        .entry_write_protect_en (entry_write_protect_en),
        .mem_req_vld            (mem_req_vld),
        .mem_ack_vld            (mem_ack_vld),
        .mem_addr               (mem_addr),
        .mem_rd_en              (mem_rd_en),
        .mem_wr_en              (mem_wr_en),
        .mem_wr_data            (mem_wr_data),
        .mem_rd_data            (mem_rd_data)
    );

    // Clock and reset.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [9:0]  a;
        logic [31:0] wd;
        logic        ev;
        logic        prot;
        int          dly;       // MEM_WAIT cycle in which memory acks; 0 = never
        logic [71:0] mrd;
        logic [31:0] exp_rd;
        int          exp_lat;
        int          exp_mcyc;
        logic        exp_mrd_en;
        logic        exp_mwr_en;
        logic [5:0]  exp_maddr;
        logic [71:0] exp_mwd;
        logic        exp_err;
    } vec_t;

    vec_t vecs[24];
    vec_t tv;

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [127:0] all_outputs();
        return 128'({ack_vld, rd_data, err, mem_req_vld, mem_addr, mem_rd_en, mem_wr_en, mem_wr_data});
    endfunction

    // Driver plus memory responder for one request; entered and left at a negedge.
    task automatic run_vec(input vec_t v, input string tag);
        int          lat;
        int          mcyc;
        bit          done;
        bit          bad_idle;
        bit          unstable;
        logic [31:0] got_rd;
        logic        got_err;
        logic        s_rd, s_wr;
        logic [5:0]  s_addr;
        logic [71:0] s_wd;
        req_vld = 1'b1;
        rd_en   = v.rd;
        wr_en   = v.wr;
        addr    = v.a;
        wr_data = v.wd;
        entry_vld = v.ev;
        entry_write_protect_en = v.prot;
        lat = 1; mcyc = 0; done = 0; bad_idle = 0; unstable = 0;
        got_rd = '0; got_err = 1'b0;
        s_rd = 1'b0; s_wr = 1'b0; s_addr = '0; s_wd = '0;
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
            mem_ack_vld = 1'b0;
            if (mem_req_vld) begin
                mcyc++;
                if (mcyc == 1) begin
                    s_rd = mem_rd_en; s_wr = mem_wr_en; s_addr = mem_addr; s_wd = mem_wr_data;
                end else if ({s_rd, s_wr, s_addr, s_wd} !== {mem_rd_en, mem_wr_en, mem_addr, mem_wr_data}) begin
                    unstable = 1;
                end
                if (mcyc == v.dly) begin
                    mem_ack_vld = 1'b1;
                    mem_rd_data = v.mrd;
                end
            end else if ({mem_rd_en, mem_wr_en, mem_addr, mem_wr_data} !== '0) begin
                bad_idle = 1;
            end
            if (ack_vld) begin
                done = 1;
                got_rd = rd_data;
                got_err = err;
            end
        end
        mem_ack_vld = 1'b0;
        check({tag, " ack_seen"}, 128'(done), 128'(1));
        check({tag, " latency"}, 128'(lat), 128'(v.exp_lat));
        check({tag, " rd_data"}, 128'(got_rd), 128'(v.exp_rd));
        check({tag, " err"}, 128'(got_err), 128'(v.exp_err));
        check({tag, " mem_cycles"}, 128'(mcyc), 128'(v.exp_mcyc));
        check({tag, " mem_idle_zero"}, 128'(bad_idle), 128'(0));
        if (v.exp_mcyc > 0) begin
            check({tag, " mem_rd_en"}, 128'(s_rd), 128'(v.exp_mrd_en));
            check({tag, " mem_wr_en"}, 128'(s_wr), 128'(v.exp_mwr_en));
            check({tag, " mem_addr"}, 128'(s_addr), 128'(v.exp_maddr));
            check({tag, " mem_wr_data"}, 128'(s_wd), 128'(v.exp_mwd));
            check({tag, " mem_stable"}, 128'(unstable), 128'(0));
        end
        req_vld = 1'b0;
        rd_en   = 1'b0;
        wr_en   = 1'b0;
        @(negedge clk);
        check({tag, " ack_pulse"}, 128'(ack_vld), 128'(0));
    endtask

    initial begin
        checks = 0;
        failures = 0;

        // Stimulus table: rd wr addr wdata ev prot dly mrd | rd_data lat mcyc mrd_en mwr_en maddr mwd err
        vecs[0]  = '{1,0,10'h000,32'h0,1,0,3,72'hAB_CDEF0123_456789AB, 32'h456789AB,5,3,1,0,6'd0,72'h0,0};
        vecs[1]  = '{1,0,10'h008,32'h0,1,0,0,72'h0, 32'h000000AB,2,0,0,0,6'd0,72'h0,0};
        vecs[2]  = '{1,0,10'h004,32'h0,1,0,0,72'h0, 32'hCDEF0123,2,0,0,0,6'd0,72'h0,0};
        vecs[3]  = '{0,1,10'h040,32'h11111111,1,0,0,72'h0, 32'h0,2,0,0,0,6'd0,72'h0,0};
        vecs[4]  = '{0,1,10'h044,32'h22222222,1,0,0,72'h0, 32'h0,2,0,0,0,6'd0,72'h0,0};
        // 0x48: entry = 0x48 >> 4 = 4, part 2 (commit)
        vecs[5]  = '{0,1,10'h048,32'h33333333,1,0,1,72'h0, 32'h0,3,1,0,1,6'd4,72'h33_22222222_11111111,0};
        vecs[6]  = '{1,0,10'h048,32'h0,1,0,0,72'h0, 32'h00000033,2,0,0,0,6'd0,72'h0,0};
        vecs[7]  = '{0,1,10'h048,32'h44444444,1,1,0,72'h0, 32'h0,2,0,0,0,6'd0,72'h0,0};
        vecs[8]  = '{1,0,10'h048,32'h0,1,0,0,72'h0, 32'h00000044,2,0,0,0,6'd0,72'h0,0};
        vecs[9]  = '{1,0,10'h000,32'h0,0,0,0,72'h0, 32'h0000005A,2,0,0,0,6'd0,72'h0,0};
        vecs[10] = '{1,0,10'h004,32'h0,1,0,0,72'h0, 32'h0,2,0,0,0,6'd0,72'h0,0};
        vecs[11] = '{1,0,10'h00C,32'h0,1,0,0,72'h0, 32'h0,2,0,0,0,6'd0,72'h0,0};
        vecs[12] = '{0,1,10'h00C,32'h77777777,1,0,0,72'h0, 32'h0,2,0,0,0,6'd0,72'h0,0};
        vecs[13] = '{1,0,10'h008,32'h0,1,0,0,72'h0, 32'h0,2,0,0,0,6'd0,72'h0,0};
        vecs[14] = '{1,1,10'h004,32'h12345678,1,0,0,72'h0, 32'h0,2,0,0,0,6'd0,72'h0,0};
        vecs[15] = '{1,0,10'h004,32'h0,1,0,0,72'h0, 32'h12345678,2,0,0,0,6'd0,72'h0,0};
        vecs[16] = '{0,0,10'h000,32'h99999999,1,0,0,72'h0, 32'h0,2,0,0,0,6'd0,72'h0,0};
        vecs[17] = '{1,0,10'h004,32'h0,1,0,0,72'h0, 32'h12345678,2,0,0,0,6'd0,72'h0,0};
        vecs[18] = '{0,1,10'h008,32'hDEADBEEF,1,0,2,72'h0, 32'h0,4,2,0,1,6'd0,72'hEF_12345678_0000005A,0};
        vecs[19] = '{1,0,10'h008,32'h0,1,0,0,72'h0, 32'h000000EF,2,0,0,0,6'd0,72'h0,0};
        vecs[20] = '{1,0,10'h010,32'h0,1,0,1,72'h01_02030405_06070809, 32'h06070809,3,1,1,0,6'd1,72'h0,0};
        vecs[21] = '{1,0,10'h014,32'h0,1,0,0,72'h0, 32'h02030405,2,0,0,0,6'd0,72'h0,0};
        // Highest entry (63), commit partition.
        vecs[22] = '{0,1,10'h3F8,32'hA5A5A5C3,1,0,1,72'h0, 32'h0,3,1,0,1,6'd63,72'hC3_02030405_06070809,0};
        vecs[23] = '{1,0,10'h3F8,32'h0,1,0,0,72'h0, 32'h000000C3,2,0,0,0,6'd0,72'h0,0};

        rst_n = 1'b0;
        req_vld = 1'b0; addr = '0; rd_en = 1'b0; wr_en = 1'b0; wr_data = '0;
        entry_vld = 1'b0; entry_write_protect_en = 1'b0;
        mem_ack_vld = 1'b0; mem_rd_data = '0;

        #3;
        check("reset_outputs", all_outputs(), 128'(0));
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_reset_outputs", all_outputs(), 128'(0));

        for (int i = 0; i < 24; i++)
            run_vec(vecs[i], $sformatf("vec%0d", i));

`ifdef SNAP_MEM_TIMEOUT_EN
        // Memory never answers: 8 MEM_WAIT cycles, then ack with err, snapshot kept.
        tv = '{1,0,10'h000,32'h0,1,0,0,72'hFF_FFFFFFFF_FFFFFFFF, 32'h0,10,8,1,0,6'd0,72'h0,1};
        run_vec(tv, "timeout");
        tv = '{1,0,10'h004,32'h0,1,0,0,72'h0, 32'h02030405,2,0,0,0,6'd0,72'h0,0};
        run_vec(tv, "timeout_snap_kept");
`endif

        // Reset while in MEM_WAIT abandons the request.
        req_vld = 1'b1; rd_en = 1'b1; addr = 10'h010; entry_vld = 1'b1;
        @(negedge clk);
        check("rst_mid_wait_req", 128'(mem_req_vld), 128'(1));
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_wait_outputs", all_outputs(), 128'(0));
        check("rst_mid_wait_state", 128'(dut.state), 128'(3'b001));
        req_vld = 1'b0; rd_en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_release_outputs", all_outputs(), 128'(0));

        // Stray memory ack while idle must be ignored.
        mem_ack_vld = 1'b1;
        @(negedge clk);
        mem_ack_vld = 1'b0;
        check("late_ack_ignored", all_outputs(), 128'(0));

        // Snapshot cleared by reset.
        tv = '{1,0,10'h014,32'h0,1,0,0,72'h0, 32'h0,2,0,0,0,6'd0,72'h0,0};
        run_vec(tv, "snap_after_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
